// File: rtl/input_conditioner.sv
// Multi-channel pin conditioner: optional inversion, N-flop synchroniser, stability-count
// debouncer and registered press/release pulses. Define INPUT_CONDITIONER_REPEAT_EN for auto-repeat.
module input_conditioner #(
  parameter int unsigned width_p           = 4,
  parameter int unsigned sync_depth_p      = 2,
  parameter int unsigned debounce_cycles_p = 16,
  parameter bit          invert_p          = 1'b1,
  parameter int unsigned repeat_delay_p    = 6000000,
  parameter int unsigned repeat_period_p   = 1200000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] async_unsafe_i,
  output logic [width_p-1:0] level_o,
  output logic [width_p-1:0] press_o,
  output logic [width_p-1:0] release_o
);

  if (sync_depth_p < 2 || debounce_cycles_p < 1 || repeat_delay_p < 1 || repeat_period_p < 1)
  begin : g_bad_params
    $error("input_conditioner: illegal parameter value");
  end

  localparam int unsigned cnt_w_lp = $clog2(debounce_cycles_p + 1);
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(debounce_cycles_p - 1);

`ifdef INPUT_CONDITIONER_REPEAT_EN
  localparam int unsigned rpt_max_lp = (repeat_delay_p > repeat_period_p) ?
                                       repeat_delay_p : repeat_period_p;
  localparam int unsigned rpt_w_lp = $clog2(rpt_max_lp + 1);
  localparam logic [rpt_w_lp-1:0] rpt_delay_last_lp  = rpt_w_lp'(repeat_delay_p - 1);
  localparam logic [rpt_w_lp-1:0] rpt_period_last_lp = rpt_w_lp'(repeat_period_p - 1);
`endif

  // Reset value 0 in the synchroniser is the inactive level once inversion is applied.
  logic [width_p-1:0] raw;
  assign raw = async_unsafe_i ^ {width_p{invert_p}};

  for (genvar i = 0; i < width_p; i++) begin : g_ch
    logic [sync_depth_p-1:0] sync_q, sync_d;
    logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
    logic                    level_q, level_d;
    logic                    press_q, press_d;
    logic                    release_q, release_d;
    logic                    s;

    assign s = sync_q[sync_depth_p-1];

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
      sync_d  = {sync_q[sync_depth_p-2:0], raw[i]};
      cnt_d   = '0;
      level_d = level_q;
      if (s != level_q) begin
        if (cnt_q == cnt_last_lp) begin
          level_d = s;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      release_d = level_q & ~level_d;
    end

`ifdef INPUT_CONDITIONER_REPEAT_EN
    logic [rpt_w_lp-1:0] rpt_q, rpt_d;
    logic                rpt_first_q, rpt_first_d;

    // The counter restarts on every press pulse; first_q selects delay vs. period.
    always_comb begin
      rpt_d       = '0;
      rpt_first_d = 1'b1;
      press_d     = ~level_q & level_d;
      if (level_q && level_d) begin
        rpt_first_d = rpt_first_q;
        if (rpt_q == (rpt_first_q ? rpt_delay_last_lp : rpt_period_last_lp)) begin
          press_d     = 1'b1;
          rpt_first_d = 1'b0;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        rpt_q       <= '0;
        rpt_first_q <= 1'b1;
      end else begin
        rpt_q       <= rpt_d;
        rpt_first_q <= rpt_first_d;
      end
    end
`else
    always_comb begin
      press_d = ~level_q & level_d;
    end
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        sync_q    <= '0;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync_q    <= sync_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign level_o[i]   = level_q;
    assign press_o[i]   = press_q;
    assign release_o[i] = release_q;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner (3 channels, depth 2, debounce 4, non-inverted);
// expected per-cycle outputs are queued at stimulus time and compared on the falling edge.
module tb_input_conditioner;

  localparam int W = 3;
`ifdef INPUT_CONDITIONER_REPEAT_EN
  localparam bit rep_en = 1'b1;
`else
  localparam bit rep_en = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] level_o, press_o, release_o;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int           cyc;
    logic [W-1:0] lvl;
    logic [W-1:0] pr;
    logic [W-1:0] rl;
    string        tag;
  } exp_t;

  exp_t sb[$];
  exp_t e_cur;

  input_conditioner #(
    .width_p          (W),
    .sync_depth_p     (2),
    .debounce_cycles_p(4),
    .invert_p         (1'b0),
    .repeat_delay_p   (20),
    .repeat_period_p  (8)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .async_unsafe_i(a),
    .level_o       (level_o),
    .press_o       (press_o),
    .release_o     (release_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic expect_span(input int c0, input int c1, input logic [W-1:0] lvl,
                             input logic [W-1:0] pr, input logic [W-1:0] rl, input string tag);
    for (int c = c0; c <= c1; c++) sb.push_back('{c, lvl, pr, rl, tag});
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_now(input string tag, input logic [W-1:0] lvl,
                           input logic [W-1:0] pr, input logic [W-1:0] rl);
    vectors++;
    assert ({level_o, press_o, release_o} === {lvl, pr, rl}) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d got lvl=%b pr=%b rl=%b want lvl=%b pr=%b rl=%b",
             tag, cyc, level_o, press_o, release_o, lvl, pr, rl);
    end
  endtask

  // Scoreboard drain: compare every queued expectation whose cycle has arrived.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e_cur = sb.pop_front();
      vectors++;
      assert ({level_o, press_o, release_o} === {e_cur.lvl, e_cur.pr, e_cur.rl}) else begin
        miscompares++;
        $error("FAIL %s cyc=%0d got lvl=%b pr=%b rl=%b want lvl=%b pr=%b rl=%b",
               e_cur.tag, cyc, level_o, press_o, release_o, e_cur.lvl, e_cur.pr, e_cur.rl);
      end
    end
  end

  initial begin
    int t;
    int pending;
    logic [W-1:0] pr;

    // Inputs active while reset is held; reset release gives a fresh press after 6 edges.
    reset_i = 1'b1;
    a       = 3'b111;
    repeat (3) @(negedge clk);
    check_now("reset_hold", 3'b000, 3'b000, 3'b000);
    t = cyc;
    reset_i = 1'b0;
    expect_span(t + 1, t + 5, 3'b000, 3'b000, 3'b000, "rst_rel_wait");
    expect_span(t + 6, t + 6, 3'b111, 3'b111, 3'b000, "rst_rel_press");
    expect_span(t + 7, t + 9, 3'b111, 3'b000, 3'b000, "rst_rel_hold");
    wait_to(t + 9);

    // Release all channels together.
    t = cyc;
    a = 3'b000;
    expect_span(t + 1, t + 5, 3'b111, 3'b000, 3'b000, "all_rel_wait");
    expect_span(t + 6, t + 6, 3'b000, 3'b000, 3'b111, "all_rel_pulse");
    expect_span(t + 7, t + 8, 3'b000, 3'b000, 3'b000, "all_rel_idle");
    wait_to(t + 8);

    // Channel 0 bounce: high for 3 cycles only, never reaches the debounce threshold.
    t = cyc;
    a = 3'b001;
    expect_span(t + 1, t + 12, 3'b000, 3'b000, 3'b000, "bounce_ch0");
    wait_to(t + 3);
    a = 3'b000;
    wait_to(t + 12);

    // Channel 1 press, then release: single release pulse 6 edges after the drop.
    t = cyc;
    a = 3'b010;
    expect_span(t + 1, t + 5, 3'b000, 3'b000, 3'b000, "ch1_press_wait");
    expect_span(t + 6, t + 6, 3'b010, 3'b010, 3'b000, "ch1_press");
    expect_span(t + 7, t + 9, 3'b010, 3'b000, 3'b000, "ch1_hold");
    expect_span(t + 10, t + 14, 3'b010, 3'b000, 3'b000, "ch1_rel_wait");
    expect_span(t + 15, t + 15, 3'b000, 3'b000, 3'b010, "ch1_release");
    expect_span(t + 16, t + 17, 3'b000, 3'b000, 3'b000, "ch1_idle");
    wait_to(t + 9);
    a = 3'b000;
    wait_to(t + 17);

    // Channels 0 and 2 pressed together while channel 1 toggles every 2 cycles.
    t = cyc;
    expect_span(t + 1, t + 5, 3'b000, 3'b000, 3'b000, "ch02_wait");
    expect_span(t + 6, t + 6, 3'b101, 3'b101, 3'b000, "ch02_press");
    expect_span(t + 7, t + 17, 3'b101, 3'b000, 3'b000, "ch02_hold_ch1_toggle");
    expect_span(t + 18, t + 18, 3'b000, 3'b000, 3'b101, "ch02_release");
    expect_span(t + 19, t + 20, 3'b000, 3'b000, 3'b000, "ch02_idle");
    for (int k = 0; k < 12; k++) begin
      wait_to(t + k);
      a = {1'b1, ((k / 2) % 2 == 0), 1'b1};
    end
    wait_to(t + 12);
    a = 3'b000;
    wait_to(t + 20);

    // Asynchronous reset while channel 0 count is at 2 and channel 2 is already high.
    t = cyc;
    a = 3'b100;
    expect_span(t + 1, t + 5, 3'b000, 3'b000, 3'b000, "pre_rst_wait");
    expect_span(t + 6, t + 6, 3'b100, 3'b100, 3'b000, "pre_rst_press");
    expect_span(t + 7, t + 10, 3'b100, 3'b000, 3'b000, "pre_rst_hold");
    wait_to(t + 6);
    a = 3'b101;
    wait_to(t + 10);
    #2 reset_i = 1'b1;
    #1 check_now("async_reset_drop", 3'b000, 3'b000, 3'b000);
    repeat (2) @(negedge clk);
    check_now("in_reset", 3'b000, 3'b000, 3'b000);
    t = cyc;
    reset_i = 1'b0;
    expect_span(t + 1, t + 5, 3'b000, 3'b000, 3'b000, "post_rst_wait");
    expect_span(t + 6, t + 6, 3'b101, 3'b101, 3'b000, "post_rst_press");
    expect_span(t + 7, t + 9, 3'b101, 3'b000, 3'b000, "post_rst_hold");
    expect_span(t + 10, t + 14, 3'b101, 3'b000, 3'b000, "post_rst_rel_wait");
    expect_span(t + 15, t + 15, 3'b000, 3'b000, 3'b101, "post_rst_release");
    expect_span(t + 16, t + 17, 3'b000, 3'b000, 3'b000, "post_rst_idle");
    wait_to(t + 9);
    a = 3'b000;
    wait_to(t + 17);

    // Long hold on channel 0: repeats at +20 then every 8 only when the macro is defined.
    t = cyc;
    a = 3'b001;
    expect_span(t + 1, t + 5, 3'b000, 3'b000, 3'b000, "hold_wait");
    expect_span(t + 6, t + 6, 3'b001, 3'b001, 3'b000, "hold_press");
    for (int c = t + 7; c <= t + 51; c++) begin
      pr = (rep_en && c >= t + 26 && ((c - (t + 26)) % 8) == 0) ? 3'b001 : 3'b000;
      expect_span(c, c, 3'b001, pr, 3'b000, "hold_repeat");
    end
    expect_span(t + 52, t + 52, 3'b000, 3'b000, 3'b001, "hold_release");
    expect_span(t + 53, t + 66, 3'b000, 3'b000, 3'b000, "hold_after_release");
    wait_to(t + 46);
    a = 3'b000;
    wait_to(t + 66);
    @(negedge clk);
    @(negedge clk);

    pending = sb.size();
    vectors++;
    assert (pending === 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain got %0d pending entries want 0", pending);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised multi-channel front end for raw board inputs such as push-buttons and PMOD switches. Each channel is inverted to active-high if required, then passed through an N-stage synchroniser and a stability-count debouncer. The block produces a clean level, a one-cycle press pulse and a one-cycle release pulse per channel. It sits between the top-level pins and the LCD/menu control logic, replacing ad-hoc per-signal synchroniser flops.

## Interface
- `width_p`, 4: number of independent channels.
- `sync_depth_p`, 2: synchroniser flops per channel; must be ≥2.
- `debounce_cycles_p`, 16: number of consecutive differing synchronised samples required to change `level_o`; must be ≥1.
- `invert_p`, 1: when 1, raw inputs are active-low and are inverted before the synchroniser.
- `repeat_delay_p`, 6000000: hold time in cycles before the first auto-repeat. Used only with the repeat macro.
- `repeat_period_p`, 1200000: interval in cycles between subsequent auto-repeats; must be ≥1. Used only with the repeat macro.

Ports:
- `clk_i`, in, 1: sole clock.
- `reset_i`, in, 1: asynchronous, active-high reset.
- `async_unsafe_i`, in, `width_p`: raw pins. Not synchronised and not debounced.
- `level_o`, out, `width_p`: debounced, active-high level.
- `press_o`, out, `width_p`: one-cycle pulse on each press, plus each auto-repeat when enabled.
- `release_o`, out, `width_p`: one-cycle pulse on each release.

## Operation
- Channels are fully independent. Each channel has its own synchroniser, debounce counter and (optionally) repeat counter.
- Conditioning: `raw = async_unsafe_i ^ {width_p{invert_p}}`. `raw` feeds a `sync_depth_p`-flop shift chain; the last stage is `s`.
- Debounce counter width is `$clog2(debounce_cycles_p+1)`. On each edge:
  - If `s == level_o`, the counter is cleared to 0.
  - Else if `count == debounce_cycles_p-1`, then `level_o <= s` and the counter is cleared.
  - Else the counter increments.
- Pulse generation:
  - `press_o` is registered and set on the edge where `level_o` goes 0→1.
  - `release_o` is registered and set on the edge where `level_o` goes 1→0.
  - Each pulse is high for exactly one cycle and coincides with the first cycle of the new level.
- Glitches: any pulse on `s` shorter than `debounce_cycles_p` cycles produces no output activity.
- Reset: all synchroniser flops, counters, `level_o`, `press_o` and `release_o` go to 0 immediately and asynchronously.
  - The synchroniser reset value of 0 corresponds to the inactive state after inversion.
  - If an input is held active through reset release, it is treated as a fresh press after the full latency.
- Reset asserted mid-count or mid-repeat aborts the count with no pulse. Counting restarts from 0 after release.

## Timing
- Latency from a stable raw change to `level_o`/pulse: `sync_depth_p + debounce_cycles_p` rising edges.
- Pulses are never back-to-back on the same channel from debouncing alone. The minimum spacing between a press and a release is `debounce_cycles_p` cycles.
- No combinational path exists from `async_unsafe_i` to any output. All outputs are registered.

## Configuration
- `INPUT_CONDITIONER_REPEAT_EN` defined:
  - Each channel has a repeat counter that is cleared whenever `level_o` is 0 or a press pulse occurs.
  - While `level_o` stays 1, `press_o` pulses again `repeat_delay_p` cycles after the initial press pulse, then every `repeat_period_p` cycles.
  - A release stops repeating immediately. `release_o` is unaffected by repeats.
- Not defined:
  - `press_o` fires only on 0→1 transitions of `level_o`.
  - The repeat parameters are ignored and no repeat counters are built.

## Test plan
All scenarios use `width_p=3`, `sync_depth_p=2`, `debounce_cycles_p=4`, `invert_p=0` unless noted.

1. Hold `reset_i`=1 with inputs `3'b111` → all outputs 0. Release reset with inputs held → `level_o=3'b111` after edge 6, and `press_o=3'b111` for exactly that one cycle.
2. Channel 0 bounce: drive 1 for 3 cycles, then 0 → `level_o[0]`, `press_o[0]` and `release_o[0]` all stay 0 throughout.
3. Channel 1 pressed and stable, then driven to 0 → `level_o[1]` falls 6 edges later with a single `release_o[1]` pulse and no `press_o[1]` activity.
4. Channels 0 and 2 pressed on the same cycle while channel 1 toggles every 2 cycles → `press_o=3'b101` as a single cycle and `level_o[1]` stays 0.
5. Assert `reset_i` asynchronously at count=2 of a pending press → outputs drop to 0 without a clock edge. After release with the input still held, the press appears after 6 edges.
6. With `INPUT_CONDITIONER_REPEAT_EN`, `repeat_delay_p=20`, `repeat_period_p=8`, channel 0 held → `press_o[0]` at t, t+20, t+28, t+36, and stops after release. Without the macro, only t.
